i2c_target: RTL and testbench

- I2C target (responder) for the 7-bit-address master in this codebase. Oversamples SCL/SDA on CLK and detects START/STOP.
- Matches the address, ACKs it, then either captures up to two written bytes or returns two bytes from WR_DATA, MSB first.
- Sits on the same wired-AND SDA bus as the master. Bus SDA = master drive AND target drive.

---
 rtl/i2c_target.sv | 242 ++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target with 7-bit address: ACKs its address, captures up to NBYTES written bytes or returns WR_DATA on reads.
// Optional macro I2C_TARGET_SYNC_EN adds a SYNC_STAGES-deep input synchronizer on SCL and SDA_IN.
module i2c_target #(
  parameter int NBYTES      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SCL,
  input  logic        SDA_IN,
  input  logic [6:0]  I2C_ADDR,
  input  logic [15:0] WR_DATA,
  output logic        SDA_OUT,
  output logic        SDA_OE,
  output logic [15:0] RD_DATA,
  output logic        RX_VALID,
  output logic        BUSY
);

`ifdef I2C_TARGET_SYNC_EN
  localparam int IN_STAGES = SYNC_STAGES + 1;
`else
  localparam int IN_STAGES = 1 + 0 * SYNC_STAGES;
`endif

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK} state_t;

  logic [IN_STAGES-1:0] scl_pipe_reg, sda_pipe_reg;
  logic                 scl_prev_reg, sda_prev_reg;
  logic                 scl_q, sda_q;
  logic                 start_det, stop_det, scl_rise, scl_fall;

  state_t      state_reg, state_next;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  tx_reg, tx_next;
  logic [1:0]  byte_idx_reg, byte_idx_next, byte_idx_inc;
  logic        rnw_reg, rnw_next;
  logic [6:0]  addr_reg, addr_next;
  logic [15:0] snap_reg, snap_next;
  logic [15:0] rd_data_reg, rd_data_next;
  logic        sda_out_reg, sda_out_next;
  logic        sda_oe_reg, sda_oe_next;
  logic        busy_reg, busy_next;
  logic        got_byte_reg, got_byte_next;
  logic        rx_valid_reg, rx_valid_next;
  logic [7:0]  next_byte;

  // History resets to 1 so the first samples after reset never look like an edge.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      scl_pipe_reg <= '1;
      sda_pipe_reg <= '1;
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
    end else begin
      scl_pipe_reg[0] <= SCL;
      sda_pipe_reg[0] <= SDA_IN;
      for (int i = 1; i < IN_STAGES; i++) begin
        scl_pipe_reg[i] <= scl_pipe_reg[i-1];
        sda_pipe_reg[i] <= sda_pipe_reg[i-1];
      end
      scl_prev_reg <= scl_q;
      sda_prev_reg <= sda_q;
    end
  end

  assign scl_q     = scl_pipe_reg[IN_STAGES-1];
  assign sda_q     = sda_pipe_reg[IN_STAGES-1];
  assign start_det = scl_q & sda_prev_reg & ~sda_q;
  assign stop_det  = scl_q & ~sda_prev_reg & sda_q;
  assign scl_rise  = scl_q & ~scl_prev_reg;
  assign scl_fall  = ~scl_q & scl_prev_reg;

  function automatic logic [7:0] read_byte(input logic [1:0] idx, input logic [15:0] snap);
    if (idx == 2'd0) return snap[15:8];
    if (idx == 2'd1 && NBYTES > 1) return snap[7:0];
    return 8'hFF;
  endfunction

  assign byte_idx_inc = (byte_idx_reg == 2'd3) ? 2'd3 : byte_idx_reg + 2'd1;
  assign next_byte    = read_byte(byte_idx_inc, snap_reg);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= '0;
      byte_idx_reg <= '0;
      rnw_reg      <= 1'b0;
      addr_reg     <= '0;
      snap_reg     <= '0;
      rd_data_reg  <= '0;
      sda_out_reg  <= 1'b1;
      sda_oe_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      got_byte_reg <= 1'b0;
      rx_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
      byte_idx_reg <= byte_idx_next;
      rnw_reg      <= rnw_next;
      addr_reg     <= addr_next;
      snap_reg     <= snap_next;
      rd_data_reg  <= rd_data_next;
      sda_out_reg  <= sda_out_next;
      sda_oe_reg   <= sda_oe_next;
      busy_reg     <= busy_next;
      got_byte_reg <= got_byte_next;
      rx_valid_reg <= rx_valid_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    tx_next       = tx_reg;
    byte_idx_next = byte_idx_reg;
    rnw_next      = rnw_reg;
    addr_next     = addr_reg;
    snap_next     = snap_reg;
    rd_data_next  = rd_data_reg;
    sda_out_next  = sda_out_reg;
    sda_oe_next   = sda_oe_reg;
    busy_next     = busy_reg;
    got_byte_next = got_byte_reg;
    rx_valid_next = 1'b0;

    if (stop_det) begin
      state_next    = IDLE;
      sda_oe_next   = 1'b0;
      sda_out_next  = 1'b1;
      busy_next     = 1'b0;
      rx_valid_next = got_byte_reg;
      got_byte_next = 1'b0;
    end else if (start_det) begin
      state_next    = ADDR;
      bit_cnt_next  = '0;
      byte_idx_next = '0;
      sda_oe_next   = 1'b0;
      sda_out_next  = 1'b1;
      addr_next     = I2C_ADDR;
      got_byte_next = 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: ;
        ADDR, WR_BYTE: begin
          if (scl_rise) begin
            shift_next   = {shift_reg[6:0], sda_q};
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall && bit_cnt_reg == 4'd8) begin
            bit_cnt_next = '0;
            if (state_reg == WR_BYTE) begin
              state_next = WR_ACK;
              // Bytes beyond NBYTES are left unacknowledged and dropped.
              if (int'(byte_idx_reg) < NBYTES) begin
                sda_oe_next   = 1'b1;
                sda_out_next  = 1'b0;
                got_byte_next = 1'b1;
                if (byte_idx_reg == 2'd0) rd_data_next[15:8] = shift_reg;
                else                      rd_data_next[7:0]  = shift_reg;
              end
            end else if (shift_reg[7:1] == addr_reg) begin
              state_next   = ADDR_ACK;
              sda_oe_next  = 1'b1;
              sda_out_next = 1'b0;
              busy_next    = 1'b1;
              snap_next    = WR_DATA;
              rnw_next     = shift_reg[0];
            end else begin
              state_next = IDLE;
              busy_next  = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rnw_reg) begin
              state_next   = RD_BYTE;
              sda_oe_next  = 1'b1;
              sda_out_next = snap_reg[15];
              tx_next      = {snap_reg[14:8], 1'b1};
              bit_cnt_next = 4'd1;
            end else begin
              state_next   = WR_BYTE;
              sda_oe_next  = 1'b0;
              sda_out_next = 1'b1;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            state_next    = WR_BYTE;
            sda_oe_next   = 1'b0;
            sda_out_next  = 1'b1;
            byte_idx_next = byte_idx_inc;
          end
        end
        RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt_reg == 4'd8) begin
              state_next   = RD_ACK;
              bit_cnt_next = '0;
              sda_oe_next  = 1'b0;
              sda_out_next = 1'b1;
            end else begin
              sda_out_next = tx_reg[7];
              tx_next      = {tx_reg[6:0], 1'b1};
              bit_cnt_next = bit_cnt_reg + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise && sda_q) begin
            state_next = IDLE;
            busy_next  = 1'b0;
          end else if (scl_fall) begin
            state_next    = RD_BYTE;
            byte_idx_next = byte_idx_inc;
            sda_oe_next   = 1'b1;
            sda_out_next  = next_byte[7];
            tx_next       = {next_byte[6:0], 1'b1};
            bit_cnt_next  = 4'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign SDA_OUT  = sda_out_reg;
  assign SDA_OE   = sda_oe_reg;
  assign RD_DATA  = rd_data_reg;
  assign RX_VALID = rx_valid_reg;
  assign BUSY     = busy_reg;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-level I2C master on a wired-AND bus, byte-level reference model, directed and random transfers.
module tb_i2c_target;
  localparam logic [6:0] OWN = 7'h42;
  localparam int NB = 2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        SCL = 1'b1;
  logic        sda_m = 1'b1;
  logic [6:0]  I2C_ADDR = OWN;
  logic [15:0] WR_DATA = 16'h0000;
  logic        SDA_OUT, SDA_OE, RX_VALID, BUSY;
  logic [15:0] RD_DATA;
  logic        sda_bus;

  assign sda_bus = sda_m & (SDA_OE ? SDA_OUT : 1'b1);

  always #5 CLK = ~CLK;

  i2c_target dut (
    .CLK(CLK), .RESET(RESET), .SCL(SCL), .SDA_IN(sda_bus),
    .I2C_ADDR(I2C_ADDR), .WR_DATA(WR_DATA),
    .SDA_OUT(SDA_OUT), .SDA_OE(SDA_OE), .RD_DATA(RD_DATA),
    .RX_VALID(RX_VALID), .BUSY(BUSY)
  );

  int n_checks = 0;
  int n_fail = 0;
  int rx_cycles = 0;
  int oe_cycles = 0;
  logic [15:0] model_rd = 16'h0000;
  logic [7:0]  wbuf [4];

  always @(negedge CLK) begin
    if (RX_VALID) rx_cycles++;
    if (SDA_OE) oe_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i, input logic [15:0] snap);
    if (i >= NB) return 8'hFF;
    return snap[15 - 8*i -: 8];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic m_bit(input logic b, output logic s);
    tick(1); sda_m = b; tick(4); SCL = 1'b1; tick(2); s = sda_bus; tick(2); SCL = 1'b0;
  endtask

  task automatic m_start;
    tick(1); sda_m = 1'b1; tick(4); SCL = 1'b1; tick(3); sda_m = 1'b0; tick(3); SCL = 1'b0;
  endtask

  task automatic m_stop;
    tick(1); sda_m = 1'b0; tick(4); SCL = 1'b1; tick(3); sda_m = 1'b1; tick(4);
  endtask

  task automatic m_write(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(d[i], s);
    m_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic m_read(input logic give_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, s);
      d[i] = s;
    end
    m_bit(~give_ack, s);
  endtask

  task automatic write_xfer(input logic [6:0] a, input int n, input bit do_stop);
    logic ack;
    bit   match;
    int   rx0, oe0;
    match = (a == I2C_ADDR);
    rx0 = rx_cycles;
    oe0 = oe_cycles;
    m_start;
    m_write({a, 1'b0}, ack);
    check("wr_addr_ack", 32'(ack), 32'(match));
    check("busy_after_addr", 32'(BUSY), 32'(match));
    for (int i = 0; i < n; i++) begin
      m_write(wbuf[i], ack);
      check("wr_data_ack", 32'(ack), 32'(match && i < NB));
      if (match && i < NB) model_rd[15 - 8*i -: 8] = wbuf[i];
    end
    check("rd_data", 32'(RD_DATA), 32'(model_rd));
    if (!match) check("oe_quiet_mismatch", 32'(oe_cycles - oe0), 32'd0);
    if (do_stop) begin
      m_stop;
      check("rx_valid_cycles", 32'(rx_cycles - rx0), (match && n > 0) ? 32'd1 : 32'd0);
      check("busy_after_stop", 32'(BUSY), 32'd0);
    end
  endtask

  task automatic read_xfer(input logic [6:0] a, input int n);
    logic        ack;
    logic [7:0]  d;
    logic [15:0] snap;
    bit          match;
    int          rx0, oe0;
    match = (a == I2C_ADDR);
    snap = WR_DATA;
    rx0 = rx_cycles;
    oe0 = oe_cycles;
    m_start;
    m_write({a, 1'b1}, ack);
    check("rd_addr_ack", 32'(ack), 32'(match));
    WR_DATA = 16'($urandom);
    for (int i = 0; i < n; i++) begin
      m_read(i < n - 1, d);
      check("rd_byte", 32'(d), match ? 32'(exp_byte(i, snap)) : 32'hFF);
    end
    check("oe_after_nack", 32'(SDA_OE), 32'd0);
    check("busy_after_nack", 32'(BUSY), 32'd0);
    if (!match) check("oe_quiet_mismatch", 32'(oe_cycles - oe0), 32'd0);
    m_stop;
    check("rx_valid_on_read", 32'(rx_cycles - rx0), 32'd0);
    check("rd_data_kept", 32'(RD_DATA), 32'(model_rd));
  endtask

  initial begin
    logic ack, s;
    int   rx0, oe0;

    tick(3);
    check("reset_sda_out", 32'(SDA_OUT), 32'd1);
    check("reset_sda_oe", 32'(SDA_OE), 32'd0);
    check("reset_rd_data", 32'(RD_DATA), 32'd0);
    check("reset_rx_valid", 32'(RX_VALID), 32'd0);
    check("reset_busy", 32'(BUSY), 32'd0);
    RESET = 1'b1;
    tick(4);

    I2C_ADDR = OWN;
    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
    write_xfer(OWN, 2, 1'b1);
    $display("write A5 5A -> RD_DATA %h", RD_DATA);

    WR_DATA = 16'hC3E1;
    read_xfer(OWN, 2);
    $display("read 2 bytes from snapshot C3E1");

    wbuf[0] = 8'hDE; wbuf[1] = 8'hAD;
    write_xfer(7'h43, 2, 1'b1);
    $display("mismatched write to 43 -> RD_DATA %h", RD_DATA);

    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    write_xfer(OWN, 3, 1'b1);
    $display("overflow write 11 22 33 -> RD_DATA %h", RD_DATA);

    wbuf[0] = 8'h77;
    write_xfer(OWN, 1, 1'b0);
    WR_DATA = 16'h9ABC;
    read_xfer(OWN, 2);
    check("rep_start_rd_hi", 32'(RD_DATA[15:8]), 32'h77);
    $display("write 77, repeated START, read -> RD_DATA %h", RD_DATA);

    WR_DATA = 16'h1234;
    m_start;
    m_write({OWN, 1'b1}, ack);
    check("midread_addr_ack", 32'(ack), 32'd1);
    tick(4);
    check("midread_driving_zero", 32'({SDA_OE, sda_bus}), 32'd2);
    RESET = 1'b0;
    tick(1);
    check("midreset_sda_oe", 32'(SDA_OE), 32'd0);
    check("midreset_rd_data", 32'(RD_DATA), 32'd0);
    check("midreset_busy", 32'(BUSY), 32'd0);
    RESET = 1'b1;
    model_rd = 16'h0000;
    rx0 = rx_cycles;
    oe0 = oe_cycles;
    for (int i = 0; i < 9; i++) m_bit(1'b1, s);
    m_stop;
    check("postreset_oe_quiet", 32'(oe_cycles - oe0), 32'd0);
    check("postreset_no_rx", 32'(rx_cycles - rx0), 32'd0);
    $display("reset during read -> target idle");

    for (int t = 0; t < 24; t++) begin
      logic [6:0] a;
      bit rnw;
      int n;
      I2C_ADDR = 7'($urandom);
      a = ($urandom_range(0, 3) != 0) ? I2C_ADDR : (I2C_ADDR ^ 7'($urandom_range(1, 127)));
      rnw = 1'($urandom);
      for (int k = 0; k < 4; k++) wbuf[k] = 8'($urandom);
      if (rnw) begin
        WR_DATA = 16'($urandom);
        n = $urandom_range(1, 3);
        read_xfer(a, n);
      end else begin
        n = $urandom_range(0, 3);
        write_xfer(a, n, 1'b1);
      end
      $display("random %0d: addr %h own %h rnw %0d bytes %0d RD_DATA %h", t, a, I2C_ADDR, rnw, n, RD_DATA);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
